// File: rtl/thread_issue_stage.sv
// thread_issue_stage: picks one ready hardware thread per cycle and issues its
// queue-head instruction to operand fetch one cycle later. Per-thread scoreboards
// track pending register writes so that RAW and WAW hazards block issue.
// Optional build macro: THREAD_ISSUE_PERF_EN adds perf_instruction_issue and
// perf_hazard_stall event outputs.

`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

package thread_issue_pkg;

  localparam int THREADS_PER_CORE = `THREADS_PER_CORE;
  localparam int THREAD_IDX_W = (THREADS_PER_CORE > 1) ? $clog2(THREADS_PER_CORE) : 1;

  typedef logic [THREAD_IDX_W-1:0] local_thread_idx_t;
  typedef logic [4:0]              register_idx_t;
  typedef logic [1:0]              subcycle_t;

  // Decoded instruction as held at the head of each thread's queue.
  typedef struct packed {
    logic [31:0]   pc;
    logic          has_scalar1;
    register_idx_t scalar_sel1;
    logic          has_scalar2;
    register_idx_t scalar_sel2;
    logic          has_vector1;
    register_idx_t vector_sel1;
    logic          has_vector2;
    register_idx_t vector_sel2;
    logic          has_dest;
    logic          dest_is_vector;
    register_idx_t dest_reg;
  } decoded_instruction_t;

endpackage

module thread_issue_stage
  import thread_issue_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [THREADS_PER_CORE-1:0]           thread_en,
  input  logic [THREADS_PER_CORE-1:0]           ifd_instruction_valid,
  input  decoded_instruction_t                  ifd_instruction [THREADS_PER_CORE],
  output logic [THREADS_PER_CORE-1:0]           ts_instruction_dequeue,
  output logic                                  ts_instruction_valid,
  output decoded_instruction_t                  ts_instruction,
  output local_thread_idx_t                     ts_thread_idx,
  output subcycle_t                             ts_subcycle,
  input  logic                                  wb_writeback_en,
  input  local_thread_idx_t                     wb_writeback_thread_idx,
  input  logic                                  wb_writeback_is_vector,
  input  register_idx_t                         wb_writeback_reg,
  input  logic                                  wb_rollback_en,
  input  local_thread_idx_t                     wb_rollback_thread_idx
`ifdef THREAD_ISSUE_PERF_EN
  ,
  output logic                                  perf_instruction_issue,
  output logic                                  perf_hazard_stall
`endif
);

  localparam int N = THREADS_PER_CORE;

  // Scoreboard layout: bits [31:0] scalar registers, bits [63:32] vector registers.
  logic [63:0]          r_scoreboard [N];
  logic [63:0]          w_scoreboard_next [N];
  local_thread_idx_t    r_last_issued;
  logic                 r_ts_valid;
  decoded_instruction_t r_ts_instruction;
  local_thread_idx_t    r_ts_thread_idx;

  logic [N-1:0]         w_rollback_hit;
  logic [N-1:0]         w_hazard;
  logic [N-1:0]         w_ready;
  logic                 w_grant_valid;
  local_thread_idx_t    w_grant_idx;
  logic                 w_issue;
  decoded_instruction_t w_grant_instr;

  // Every register an instruction touches (sources and destination), as a scoreboard mask.
  function automatic logic [63:0] depMask(input decoded_instruction_t ins);
    logic [63:0] m;
    m = '0;
    if (ins.has_scalar1)
      m[{1'b0, ins.scalar_sel1}] = 1'b1;
    if (ins.has_scalar2)
      m[{1'b0, ins.scalar_sel2}] = 1'b1;
    if (ins.has_vector1)
      m[{1'b1, ins.vector_sel1}] = 1'b1;
    if (ins.has_vector2)
      m[{1'b1, ins.vector_sel2}] = 1'b1;
    if (ins.has_dest)
      m[{ins.dest_is_vector, ins.dest_reg}] = 1'b1;
    return m;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_thread

    // Readiness uses only the registered scoreboard, so a writeback unblocks a
    // dependent instruction one cycle later rather than through a long comb path.
    always_comb begin
      w_rollback_hit[g] = wb_rollback_en && (wb_rollback_thread_idx == local_thread_idx_t'(g));
      w_hazard[g]       = |(depMask(ifd_instruction[g]) & r_scoreboard[g]);
      w_ready[g]        = thread_en[g] && ifd_instruction_valid[g] && !w_rollback_hit[g] && !w_hazard[g];
    end

    // Next scoreboard: writeback clear, then rollback wipe, then issue set, so a
    // set always wins over a clear landing in the same cycle.
    always_comb begin
      w_scoreboard_next[g] = r_scoreboard[g];
      if (wb_writeback_en && (wb_writeback_thread_idx == local_thread_idx_t'(g)))
        w_scoreboard_next[g][{wb_writeback_is_vector, wb_writeback_reg}] = 1'b0;
      if (w_rollback_hit[g])
        w_scoreboard_next[g] = '0;
      if (w_issue && (w_grant_idx == local_thread_idx_t'(g)) && w_grant_instr.has_dest)
        w_scoreboard_next[g][{w_grant_instr.dest_is_vector, w_grant_instr.dest_reg}] = 1'b1;
    end

    // Scoreboard storage; reset discards every pending write.
    always_ff @(posedge clk) begin
      if (reset)
        r_scoreboard[g] <= '0;
      else
        r_scoreboard[g] <= w_scoreboard_next[g];
    end

  end

  // Round-robin search starting one past the last issued thread, wrapping.
  always_comb begin
    local_thread_idx_t w_cand;
    w_cand        = '0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = local_thread_idx_t'((int'(r_last_issued) + i) % N);
      if (!w_grant_valid && w_ready[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  // Dequeue pulse goes straight back to the chosen queue; nothing leaves during reset.
  always_comb begin
    w_issue                = w_grant_valid && !reset;
    w_grant_instr          = ifd_instruction[w_grant_idx];
    ts_instruction_dequeue = '0;
    if (w_issue)
      ts_instruction_dequeue[w_grant_idx] = 1'b1;
  end

  // Issue valid and the fairness pointer; the pointer only moves when something issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts_valid    <= 1'b0;
      r_last_issued <= local_thread_idx_t'(N - 1);
    end else begin
      r_ts_valid <= w_issue;
      if (w_issue)
        r_last_issued <= w_grant_idx;
    end
  end

  // Issue payload is don't-care while valid is low, so it is captured without reset.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_ts_instruction <= w_grant_instr;
      r_ts_thread_idx  <= w_grant_idx;
    end
  end

  assign ts_instruction_valid = r_ts_valid;
  assign ts_instruction       = r_ts_instruction;
  assign ts_thread_idx        = r_ts_thread_idx;
  assign ts_subcycle          = '0;

`ifdef THREAD_ISSUE_PERF_EN
  // Event pulses: an issue this cycle, or a thread held back purely by the scoreboard.
  always_comb begin
    perf_instruction_issue = w_issue;
    perf_hazard_stall      = !reset && |(thread_en & ifd_instruction_valid & ~w_rollback_hit & w_hazard);
  end
`endif

endmodule

// File: tb/tb_thread_issue_stage.sv
// tb_thread_issue_stage: directed table vectors for the round-robin order and
// thread enables, plus hand-written sequences for scoreboard hazards, rollback
// and mid-operation reset. Assumes THREADS_PER_CORE = 4.
`timescale 1ns/1ps

module tb_thread_issue_stage;
  import thread_issue_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           threadEn;
  logic [3:0]           instrValid;
  decoded_instruction_t instr [4];
  logic [3:0]           dequeue;
  logic                 tsValid;
  decoded_instruction_t tsInstr;
  local_thread_idx_t    tsThreadIdx;
  subcycle_t            tsSubcycle;
  logic                 wbEn;
  local_thread_idx_t    wbThreadIdx;
  logic                 wbIsVector;
  register_idx_t        wbReg;
  logic                 rbEn;
  local_thread_idx_t    rbThreadIdx;
`ifdef THREAD_ISSUE_PERF_EN
  logic                 perfIssue;
  logic                 perfStall;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] en;
    logic [3:0] vld;
    logic [3:0] expDeq;
    logic       expValid;
    logic [1:0] expTidx;
  } vec_t;

  vec_t vecs [12];

  thread_issue_stage dut (
    .clk                     (clk),
    .reset                   (reset),
    .thread_en               (threadEn),
    .ifd_instruction_valid   (instrValid),
    .ifd_instruction         (instr),
    .ts_instruction_dequeue  (dequeue),
    .ts_instruction_valid    (tsValid),
    .ts_instruction          (tsInstr),
    .ts_thread_idx           (tsThreadIdx),
    .ts_subcycle             (tsSubcycle),
    .wb_writeback_en         (wbEn),
    .wb_writeback_thread_idx (wbThreadIdx),
    .wb_writeback_is_vector  (wbIsVector),
    .wb_writeback_reg        (wbReg),
    .wb_rollback_en          (rbEn),
    .wb_rollback_thread_idx  (rbThreadIdx)
`ifdef THREAD_ISSUE_PERF_EN
    ,
    .perf_instruction_issue  (perfIssue),
    .perf_hazard_stall       (perfStall)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  function automatic decoded_instruction_t plainInstr(input logic [31:0] pc);
    decoded_instruction_t d;
    d    = '0;
    d.pc = pc;
    return d;
  endfunction

  function automatic decoded_instruction_t destInstr(input logic [31:0] pc, input logic isVec, input logic [4:0] r);
    decoded_instruction_t d;
    d                = plainInstr(pc);
    d.has_dest       = 1'b1;
    d.dest_is_vector = isVec;
    d.dest_reg       = r;
    return d;
  endfunction

  task automatic checkOutput(input string name, input string field, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s/%s actual=%0h expected=%0h", name, field, actual, expected);
    end
  endtask

  // Entered right after a negedge with inputs already driven: checks the
  // combinational dequeue, then the registered issue after the next rising edge,
  // and returns at the following negedge with the one-cycle pulses dropped.
  task automatic applyCycle(input string name, input logic [3:0] expDeq, input logic expValid,
                            input logic [1:0] expTidx, input logic [31:0] expPc);
    #1;
    checkOutput(name, "dequeue", 64'(dequeue), 64'(expDeq));
    @(posedge clk);
    #1;
    checkOutput(name, "valid", 64'(tsValid), 64'(expValid));
    if (expValid) begin
      checkOutput(name, "thread", 64'(tsThreadIdx), 64'(expTidx));
      checkOutput(name, "pc", 64'(tsInstr.pc), 64'(expPc));
      checkOutput(name, "subcycle", 64'(tsSubcycle), 64'd0);
    end
    @(negedge clk);
    wbEn = 1'b0;
    rbEn = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    threadEn   = vecs[idx].en;
    instrValid = vecs[idx].vld;
    for (int t = 0; t < 4; t++)
      instr[t] = plainInstr(32'h100 + 32'(t));
    applyCycle($sformatf("vec%0d", idx), vecs[idx].expDeq, vecs[idx].expValid,
               vecs[idx].expTidx, 32'h100 + 32'(vecs[idx].expTidx));
  endtask

  task automatic doReset();
    reset      = 1'b1;
    threadEn   = 4'b0000;
    instrValid = 4'b0000;
    wbEn       = 1'b0;
    rbEn       = 1'b0;
    for (int t = 0; t < 4; t++)
      instr[t] = plainInstr(32'h0);
    applyCycle("reset", 4'b0000, 1'b0, 2'd0, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    threadEn    = '0;
    instrValid  = '0;
    wbEn        = 1'b0;
    wbThreadIdx = '0;
    wbIsVector  = 1'b0;
    wbReg       = '0;
    rbEn        = 1'b0;
    rbThreadIdx = '0;
    for (int t = 0; t < 4; t++)
      instr[t] = plainInstr(32'h0);

    //           en       vld      expDeq   valid tidx
    vecs[0]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[6]  = '{4'b0101, 4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[7]  = '{4'b0101, 4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[8]  = '{4'b0101, 4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[9]  = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0};
    vecs[10] = '{4'b1010, 4'b1010, 4'b1000, 1'b1, 2'd3};
    vecs[11] = '{4'b1010, 4'b1010, 4'b0010, 1'b1, 2'd1};

    @(negedge clk);
    doReset();

    // Round-robin order and thread enables.
    for (int i = 0; i < 12; i++)
      applyStimulus(i);

    // RAW on s5 for thread 0, released only by the matching writeback.
    doReset();
    threadEn   = 4'b0001;
    instrValid = 4'b0001;
    instr[0]   = destInstr(32'h200, 1'b0, 5'd5);
    applyCycle("raw_issue", 4'b0001, 1'b1, 2'd0, 32'h200);
    instr[0]             = plainInstr(32'h201);
    instr[0].has_scalar1 = 1'b1;
    instr[0].scalar_sel1 = 5'd5;
    applyCycle("raw_stall0", 4'b0000, 1'b0, 2'd0, 32'h0);
    wbEn = 1'b1; wbThreadIdx = 2'd0; wbIsVector = 1'b0; wbReg = 5'd4;
    applyCycle("raw_wb_s4", 4'b0000, 1'b0, 2'd0, 32'h0);
    wbEn = 1'b1; wbThreadIdx = 2'd0; wbIsVector = 1'b1; wbReg = 5'd5;
    applyCycle("raw_wb_v5", 4'b0000, 1'b0, 2'd0, 32'h0);
    wbEn = 1'b1; wbThreadIdx = 2'd1; wbIsVector = 1'b0; wbReg = 5'd5;
    applyCycle("raw_wb_t1", 4'b0000, 1'b0, 2'd0, 32'h0);
    wbEn = 1'b1; wbThreadIdx = 2'd0; wbIsVector = 1'b0; wbReg = 5'd5;
    applyCycle("raw_wb_s5", 4'b0000, 1'b0, 2'd0, 32'h0);
    applyCycle("raw_release", 4'b0001, 1'b1, 2'd0, 32'h201);

    // WAW on v3 for thread 1 while thread 2 writes its own v3 freely.
    doReset();
    threadEn   = 4'b0110;
    instrValid = 4'b0010;
    instr[1]   = destInstr(32'h300, 1'b1, 5'd3);
    applyCycle("waw_first", 4'b0010, 1'b1, 2'd1, 32'h300);
    instrValid = 4'b0110;
    instr[1]   = destInstr(32'h301, 1'b1, 5'd3);
    instr[2]   = destInstr(32'h310, 1'b1, 5'd3);
    applyCycle("waw_other", 4'b0100, 1'b1, 2'd2, 32'h310);
    instrValid = 4'b0010;
    applyCycle("waw_block", 4'b0000, 1'b0, 2'd0, 32'h0);
    wbEn = 1'b1; wbThreadIdx = 2'd1; wbIsVector = 1'b1; wbReg = 5'd3;
    applyCycle("waw_wb", 4'b0000, 1'b0, 2'd0, 32'h0);
    applyCycle("waw_release", 4'b0010, 1'b1, 2'd1, 32'h301);

    // Rollback of thread 2 with s1, s7, v9 pending; thread 0 sets s2 meanwhile.
    doReset();
    threadEn   = 4'b0100;
    instrValid = 4'b0100;
    instr[2]   = destInstr(32'h400, 1'b0, 5'd1);
    applyCycle("rb_set_s1", 4'b0100, 1'b1, 2'd2, 32'h400);
    instr[2]   = destInstr(32'h401, 1'b0, 5'd7);
    applyCycle("rb_set_s7", 4'b0100, 1'b1, 2'd2, 32'h401);
    instr[2]   = destInstr(32'h402, 1'b1, 5'd9);
    applyCycle("rb_set_v9", 4'b0100, 1'b1, 2'd2, 32'h402);
    instr[2]             = plainInstr(32'h403);
    instr[2].has_scalar1 = 1'b1;
    instr[2].scalar_sel1 = 5'd1;
    instr[2].has_scalar2 = 1'b1;
    instr[2].scalar_sel2 = 5'd7;
    instr[2].has_vector1 = 1'b1;
    instr[2].vector_sel1 = 5'd9;
    applyCycle("rb_blocked", 4'b0000, 1'b0, 2'd0, 32'h0);
    threadEn    = 4'b0101;
    instrValid  = 4'b0101;
    instr[2]    = plainInstr(32'h404);
    instr[0]    = destInstr(32'h410, 1'b0, 5'd2);
    rbEn        = 1'b1;
    rbThreadIdx = 2'd2;
    applyCycle("rb_cycle", 4'b0001, 1'b1, 2'd0, 32'h410);
    instrValid           = 4'b0001;
    instr[0]             = plainInstr(32'h411);
    instr[0].has_scalar2 = 1'b1;
    instr[0].scalar_sel2 = 5'd2;
    applyCycle("rb_keep_s2", 4'b0000, 1'b0, 2'd0, 32'h0);
    instrValid           = 4'b0101;
    instr[2]             = plainInstr(32'h403);
    instr[2].has_scalar1 = 1'b1;
    instr[2].scalar_sel1 = 5'd1;
    instr[2].has_scalar2 = 1'b1;
    instr[2].scalar_sel2 = 5'd7;
    instr[2].has_vector1 = 1'b1;
    instr[2].vector_sel1 = 5'd9;
    applyCycle("rb_cleared", 4'b0100, 1'b1, 2'd2, 32'h403);

    // Reset while s2 is pending and the output is valid.
    reset      = 1'b1;
    threadEn   = 4'b1111;
    instrValid = 4'b1111;
    instr[1]   = plainInstr(32'h421);
    instr[2]   = plainInstr(32'h422);
    instr[3]   = plainInstr(32'h423);
    applyCycle("midreset", 4'b0000, 1'b0, 2'd0, 32'h0);
    reset = 1'b0;
    applyCycle("after_reset", 4'b0001, 1'b1, 2'd0, 32'h411);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
